dvi_timing_gen: RTL and testbench

- Video timing controller for the DVI output path. It sequences the DVI transmitter interface.
- Generates oDviHsync, oDviVsync and oDviDe, plus pixel coordinates and a one-cycle-early pixel request so a pixel source with 1-cycle latency can feed oDviData.
- Runs in the pixel clock domain. Replaces the constant tie-offs currently driven at the top level.

---
 rtl/dvi_timing_gen_pkg.sv | 50 +++++
 rtl/dvi_timing_gen_if.sv | 26 ++
 rtl/dvi_axis_counter.sv | 37 +++
 rtl/dvi_timing_gen.sv | 151 +++++++++++++++
 tb/tb_dvi_timing_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dvi_timing_gen_pkg.sv
// Shared types, timing presets and phase-boundary helper for the DVI timing generator.
// No logic: constants and elaboration-time functions only.
package dvi_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_STOP_PENDING
    } state_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } timing_t;

    typedef struct packed {
        int total;
        int sync_start;
        int sync_end;
    } axis_bounds_t;

    localparam timing_t TIMING_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    localparam timing_t TIMING_1024X768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};

    function automatic timing_t timing_preset(input bit xga);
        return xga ? TIMING_1024X768_60 : TIMING_640X480_60;
    endfunction

    localparam timing_t TIMING_DEFAULT = timing_preset(1'b0);

    // Axis layout is active, front porch, sync, back porch; sync_end is inclusive.
    function automatic axis_bounds_t axis_bounds(input int active, input int fp,
                                                 input int sync, input int bp);
        axis_bounds_t b;
        b.total      = active + fp + sync + bp;
        b.sync_start = active + fp;
        b.sync_end   = active + fp + sync - 1;
        return b;
    endfunction

endpackage

// File: rtl/dvi_timing_gen_if.sv
// Video timing bundle between the generator (master) and the DVI output path (slave).
// Level-sensitive run request in, registered timing/coordinate outputs back; no backpressure.
interface dvi_timing_gen_if #(
    parameter int CNT_W = 12
);
    logic             iEnable;
    logic             oPixReq;
    logic             oHsync;
    logic             oVsync;
    logic             oDe;
    logic [CNT_W-1:0] oX;
    logic [CNT_W-1:0] oY;
    logic             oLineStart;
    logic             oFrameStart;
    logic             oRunning;

    modport master (
        input  iEnable,
        output oPixReq, oHsync, oVsync, oDe, oX, oY, oLineStart, oFrameStart, oRunning
    );

    modport slave (
        output iEnable,
        input  oPixReq, oHsync, oVsync, oDe, oX, oY, oLineStart, oFrameStart, oRunning
    );
endinterface

// File: rtl/dvi_axis_counter.sv
// Wrapping position counter for one video axis with active/sync/last phase flags.
// Flags are combinational from the count; advances only on i_adv, so no backpressure.
module dvi_axis_counter
    import dvi_timing_pkg::*;
#(
    parameter int CNT_W  = 12,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_adv,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_active,
    output logic             o_sync,
    output logic             o_last
);
    localparam axis_bounds_t B = axis_bounds(ACTIVE, FP, SYNC, BP);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_adv) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_last   = (r_cnt == CNT_W'(B.total - 1));
    assign o_active = (r_cnt < CNT_W'(ACTIVE));
    assign o_sync   = (r_cnt >= CNT_W'(B.sync_start)) && (r_cnt <= CNT_W'(B.sync_end));

endmodule

// File: rtl/dvi_timing_gen.sv
// DVI video timing generator: hsync/vsync/de, coordinates and a one-cycle-early pixel request.
// Latency: enable sampled -> oPixReq next cycle -> (0,0) on outputs one cycle later; no backpressure.
module dvi_timing_gen
    import dvi_timing_pkg::*;
#(
    parameter int H_ACTIVE = TIMING_DEFAULT.h_active,
    parameter int H_FP     = TIMING_DEFAULT.h_fp,
    parameter int H_SYNC   = TIMING_DEFAULT.h_sync,
    parameter int H_BP     = TIMING_DEFAULT.h_bp,
    parameter int V_ACTIVE = TIMING_DEFAULT.v_active,
    parameter int V_FP     = TIMING_DEFAULT.v_fp,
    parameter int V_SYNC   = TIMING_DEFAULT.v_sync,
    parameter int V_BP     = TIMING_DEFAULT.v_bp,
    parameter bit HS_POL   = TIMING_DEFAULT.hs_pol,
    parameter bit VS_POL   = TIMING_DEFAULT.vs_pol,
    parameter int CNT_W    = 12
)(
    input  logic             iSysClk,
    input  logic             iSysRst,
    dvi_timing_gen_if.master io_vid
);
    localparam axis_bounds_t H_B = axis_bounds(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam axis_bounds_t V_B = axis_bounds(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam longint CNT_RANGE = longint'(1) << CNT_W;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CNT_W < 1 ||
        CNT_RANGE <= longint'(H_B.total) || CNT_RANGE <= longint'(V_B.total)) begin : g_param_check
        $error("dvi_timing_gen: timing parameters out of range for CNT_W");
    end

    state_t           r_state, w_next_state;
    logic             w_feed;
    logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
    logic             w_h_act, w_h_sync, w_h_last;
    logic             w_v_act, w_v_sync, w_v_last;
    logic             r_at_origin;

    logic             r_s1_vld, r_pix_req, r_s1_hs, r_s1_vs, r_s1_ls, r_s1_fs;
    logic [CNT_W-1:0] r_s1_x, r_s1_y;
    logic             r_de, r_hs, r_vs, r_ls, r_fs, r_running;
    logic [CNT_W-1:0] r_x, r_y;

    // The counters run two positions ahead of the outputs: stage 1 drives oPixReq, stage 2 the rest.
    dvi_axis_counter #(.CNT_W(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_cnt (
        .i_clk(iSysClk), .i_rst(iSysRst), .i_adv(w_feed),
        .o_cnt(w_h_cnt), .o_active(w_h_act), .o_sync(w_h_sync), .o_last(w_h_last)
    );

    dvi_axis_counter #(.CNT_W(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_cnt (
        .i_clk(iSysClk), .i_rst(iSysRst), .i_adv(w_feed && w_h_last),
        .o_cnt(w_v_cnt), .o_active(w_v_act), .o_sync(w_v_sync), .o_last(w_v_last)
    );

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // While stopping, the first position of a new frame is never fed, so the pipeline drains
    // at the frame's last position. An empty stage 1 with enable back high restarts via PRIME.
    always_comb begin
        w_next_state = r_state;
        w_feed       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_vid.iEnable) begin
                    w_next_state = ST_PRIME;
                    w_feed       = 1'b1;
                end
            end
            ST_PRIME: begin
                w_next_state = ST_RUN;
                w_feed       = 1'b1;
            end
            ST_RUN, ST_STOP_PENDING: begin
                w_feed = io_vid.iEnable || !r_at_origin;
                if (io_vid.iEnable) begin
                    w_next_state = r_s1_vld ? ST_RUN : ST_PRIME;
                end else begin
                    w_next_state = r_s1_vld ? ST_STOP_PENDING : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            r_at_origin <= 1'b1;
            r_s1_vld    <= 1'b0;
            r_pix_req   <= 1'b0;
            r_s1_hs     <= ~HS_POL;
            r_s1_vs     <= ~VS_POL;
            r_s1_ls     <= 1'b0;
            r_s1_fs     <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
        end else begin
            if (w_feed) begin
                r_at_origin <= w_h_last && w_v_last;
            end
            r_s1_vld  <= w_feed;
            r_pix_req <= w_feed && w_h_act && w_v_act;
            r_s1_hs   <= (w_feed && w_h_sync) ? HS_POL : ~HS_POL;
            r_s1_vs   <= (w_feed && w_v_sync) ? VS_POL : ~VS_POL;
            r_s1_ls   <= w_feed && (w_h_cnt == '0);
            r_s1_fs   <= w_feed && r_at_origin;
            r_s1_x    <= w_h_cnt;
            r_s1_y    <= w_v_cnt;
        end
    end

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            r_de      <= 1'b0;
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
            r_ls      <= 1'b0;
            r_fs      <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_running <= 1'b0;
        end else begin
            r_de      <= r_pix_req;
            r_hs      <= r_s1_hs;
            r_vs      <= r_s1_vs;
            r_ls      <= r_s1_ls;
            r_fs      <= r_s1_fs;
            r_running <= (w_next_state == ST_RUN) || (w_next_state == ST_STOP_PENDING);
            if (r_pix_req) begin
                r_x <= r_s1_x;
                r_y <= r_s1_y;
            end
        end
    end

    assign io_vid.oPixReq     = r_pix_req;
    assign io_vid.oHsync      = r_hs;
    assign io_vid.oVsync      = r_vs;
    assign io_vid.oDe         = r_de;
    assign io_vid.oX          = r_x;
    assign io_vid.oY          = r_y;
    assign io_vid.oLineStart  = r_ls;
    assign io_vid.oFrameStart = r_fs;
    assign io_vid.oRunning    = r_running;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench for dvi_timing_gen on a tiny 8x6 raster: expected output vectors are queued
// as stimulus is planned and compared, one per clock, as the DUT produces them.
module tb_dvi_timing_gen;

    typedef struct packed {
        logic        pixreq;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic        run;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    string tag;
    exp_t exp_q[$];
    logic [11:0] exp_x;
    logic [11:0] exp_y;

    dvi_timing_gen_if #(.CNT_W(12)) vid ();

    dvi_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
    ) dut (
        .iSysClk(clk),
        .iSysRst(rst),
        .io_vid (vid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic string fmt(input exp_t v);
        return $sformatf("pr=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b",
                         v.pixreq, v.hs, v.vs, v.de, v.x, v.y, v.ls, v.fs, v.run);
    endfunction

    function automatic exp_t observed();
        exp_t a;
        a.pixreq = vid.oPixReq;
        a.hs     = vid.oHsync;
        a.vs     = vid.oVsync;
        a.de     = vid.oDe;
        a.x      = vid.oX;
        a.y      = vid.oY;
        a.ls     = vid.oLineStart;
        a.fs     = vid.oFrameStart;
        a.run    = vid.oRunning;
        return a;
    endfunction

    task automatic check_vec(input exp_t e);
        exp_t a;
        a = observed();
        n_checks++;
        assert (a === e) else begin
            n_errors++;
            $error("FAIL %s: got %s, expected %s", tag, fmt(a), fmt(e));
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pixreq = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
            e.x = exp_x; e.y = exp_y; e.ls = 1'b0; e.fs = 1'b0; e.run = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Raster 8x6: active h<4, v<3; hsync low at h=5,6; vsync low on line 4.
    task automatic push_pos(input int h, input int v);
        exp_t e;
        exp_t prev;
        logic de;
        de = (h < 4) && (v < 3);
        if (de) begin
            exp_x = 12'(h);
            exp_y = 12'(v);
            if (exp_q.size() > 0) begin
                prev = exp_q.pop_back();
                prev.pixreq = 1'b1;
                exp_q.push_back(prev);
            end
        end
        e.pixreq = 1'b0;
        e.hs     = !(h == 5 || h == 6);
        e.vs     = (v != 4);
        e.de     = de;
        e.x      = exp_x;
        e.y      = exp_y;
        e.ls     = (h == 0);
        e.fs     = (h == 0) && (v == 0);
        e.run    = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_frame();
        for (int v = 0; v < 6; v++) begin
            for (int h = 0; h < 8; h++) begin
                push_pos(h, v);
            end
        end
    endtask

    task automatic step(input logic en);
        exp_t e;
        vid.iEnable = en;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: scoreboard empty, got %s, expected a queued vector", tag, fmt(observed()));
        end else begin
            e = exp_q.pop_front();
            check_vec(e);
        end
    endtask

    task automatic steps(input int n, input logic en);
        for (int i = 0; i < n; i++) step(en);
    endtask

    exp_t rst_vec;

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_x = '0;
        exp_y = '0;
        rst_vec = '{pixreq:1'b0, hs:1'b1, vs:1'b1, de:1'b0, x:12'd0, y:12'd0, ls:1'b0, fs:1'b0, run:1'b0};
        vid.iEnable = 1'b0;
        rst = 1'b1;

        tag = "reset_hold";
        repeat (3) @(posedge clk);
        #1;
        check_vec(rst_vec);
        @(negedge clk);
        rst = 1'b0;

        tag = "idle_no_enable";
        push_idle(4);
        steps(4, 1'b0);

        // Two back-to-back frames, then a stop requested at (1,1) of the third.
        tag = "run_frames";
        push_idle(1);
        push_frame();
        push_frame();
        push_frame();
        steps(1 + 96, 1'b1);
        tag = "stop_at_1_1";
        steps(10, 1'b1);
        steps(38, 1'b0);
        tag = "idle_after_stop";
        push_idle(3);
        steps(3, 1'b0);

        // Stop requested, then withdrawn at (2,5): the next frame must follow seamlessly.
        tag = "reenable_seamless";
        push_idle(1);
        push_frame();
        push_frame();
        push_idle(3);
        step(1'b1);
        steps(9, 1'b1);
        steps(34, 1'b0);
        steps(5, 1'b1);
        tag = "frame_after_reenable";
        steps(48, 1'b0);
        steps(3, 1'b0);

        tag = "one_clock_pulse";
        push_idle(1);
        push_frame();
        push_idle(4);
        step(1'b1);
        steps(52, 1'b0);

        // Reset asserted mid-line must take effect before the next clock edge.
        tag = "pre_reset_run";
        push_idle(1);
        push_frame();
        steps(11, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        tag = "reset_mid_line";
        check_vec(rst_vec);
        exp_q.delete();
        exp_x = '0;
        exp_y = '0;
        vid.iEnable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        tag = "idle_after_reset";
        push_idle(2);
        steps(2, 1'b0);
        tag = "restart_after_reset";
        push_idle(1);
        push_frame();
        push_idle(2);
        steps(11, 1'b1);
        steps(40, 1'b0);

        tag = "sb_drain";
        n_checks++;
        assert (exp_q.size() === 0) else begin
            n_errors++;
            $error("FAIL %s: %0d vectors left, expected 0", tag, exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
